obc_da_bin_engine: RTL and testbench

Parametrised, sequential offset-binary-coding (OBC) distributed-arithmetic engine that computes one DFT output component from 2·NPAIR two's-complement samples. It replaces the fixed combinational pair-XOR coefficient ROMs with a run-time loadable coefficient table and offset register. It processes one bit-slice per clock under a valid/ready handshake. One instance serves one bin component (real or imaginary); the DFT top instantiates one per component and loads each table from the controller at configuration time.

---
 rtl/obc_da_bin_engine.sv | 169 ++++++++++++++++
 tb/tb_obc_da_bin_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obc_da_bin_engine.sv
`default_nettype none
// ============================================================================
//  Module   : obc_da_bin_engine
//  Purpose  : Bit-serial offset-binary-coding distributed-arithmetic engine.
//             Computes one DFT output component from 2*NPAIR signed samples
//             using a run-time loadable pair-coefficient table and offset.
//             One bit-slice is processed per clock; valid/ready handshakes
//             on both the sample and result sides.
//  Revision : 1.0 - initial release
// ============================================================================
module obc_da_bin_engine #(
    parameter  int NPAIR = 8,
    parameter  int DW    = 16,
    parameter  int CW    = 32,
    localparam int RW    = CW + DW + $clog2(NPAIR) + 1,
    localparam int CAW   = $clog2(2 * NPAIR + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CAW-1:0]          cfg_addr,
    input  logic [CW-1:0]           cfg_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*NPAIR*DW-1:0]   x_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [RW-1:0]    y_out,
    output logic                    busy
);

    localparam int NC  = 2 * NPAIR;
    localparam int IAW = $clog2(NC);
    localparam int BW  = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [CAW-1:0] c_off_addr = CAW'(NC);
    localparam logic [BW-1:0]  c_last_bit = BW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [BW-1:0]           r_bit;
    logic [2*NPAIR*DW-1:0]   r_x;
    logic signed [CW-1:0]    r_coef [NC];
    logic signed [CW-1:0]    r_offset;
    logic signed [RW-1:0]    r_acc;
    logic signed [RW-1:0]    r_y;

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_cfg_ok;
    logic                    w_sel;
    logic signed [CW-1:0]    w_pick;
    logic signed [RW-1:0]    w_slice;
    logic signed [RW-1:0]    w_term;
    logic signed [RW-1:0]    w_acc_next;
    logic signed [RW-1:0]    w_offset_ext;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & in_valid;
    assign w_last   = (r_bit == c_last_bit);
    // Table is only writable while idle so it stays frozen for a whole run
    assign w_cfg_ok = cfg_we & w_idle & (cfg_addr <= c_off_addr);

    assign w_offset_ext = {{(RW-CW){r_offset[CW-1]}}, r_offset};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: IDLE -> BUSY on accept, BUSY -> DONE after last slice,
    // DONE -> IDLE once the result is taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_BUSY;
            S_BUSY:  if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Coefficient table and offset register, loadable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NC; i++) begin
                r_coef[i] <= '0;
            end
            r_offset <= '0;
        end else if (w_cfg_ok) begin
            if (cfg_addr == c_off_addr) begin
                r_offset <= cfg_data;
            end else begin
                r_coef[cfg_addr[IAW-1:0]] <= cfg_data;
            end
        end
    end

    // Slice sum: each pair's XOR bit selects one of its two table entries;
    // the current bit of every sample sits at the bottom of its lane in r_x
    always_comb begin
        w_slice = '0;
        w_sel   = 1'b0;
        w_pick  = '0;
        for (int p = 0; p < NPAIR; p++) begin
            w_sel   = r_x[2*p*DW] ^ r_x[(2*p+1)*DW];
            w_pick  = w_sel ? r_coef[2*p+1] : r_coef[2*p];
            w_slice = w_slice + {{(RW-CW){w_pick[CW-1]}}, w_pick};
        end
    end

    // Weighted slice: the sign-bit slice carries negative weight
    always_comb begin
        w_term     = w_slice <<< r_bit;
        w_acc_next = w_last ? (r_acc - w_term) : (r_acc + w_term);
    end

    // Datapath: capture samples, shift one bit per cycle, accumulate, and
    // register the final offset-corrected result on the last slice
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_bit <= '0;
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x   <= x_in;
                        r_acc <= '0;
                        r_bit <= '0;
                    end
                end
                S_BUSY: begin
                    // Whole-vector shift: lane k bit 0 only ever sees bits of
                    // sample k within the DW slices of one run
                    r_x   <= r_x >> 1;
                    r_bit <= r_bit + BW'(1);
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_y <= w_acc_next + w_offset_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = w_idle;
    assign out_valid = (r_state == S_DONE);
    assign busy      = ~w_idle;
    assign y_out     = r_y;

endmodule
`default_nettype wire

// File: tb/tb_obc_da_bin_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obc_da_bin_engine
//  Purpose  : Scoreboard bench for obc_da_bin_engine with a reference model
//             evaluating y = offset + sum_b w_b * S_b directly on integers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obc_da_bin_engine;

    localparam int NPAIR = 8;
    localparam int DW    = 16;
    localparam int CW    = 32;
    localparam int RW    = CW + DW + $clog2(NPAIR) + 1;
    localparam int CAW   = $clog2(2 * NPAIR + 1);
    localparam int NC    = 2 * NPAIR;
    localparam int XW    = NC * DW;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_we;
    logic [CAW-1:0]        cfg_addr;
    logic [CW-1:0]         cfg_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [XW-1:0]         x_in;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [RW-1:0]  y_out;
    logic                  busy;

    obc_da_bin_engine #(.NPAIR(NPAIR), .DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic signed [RW-1:0] sb_q [$];
    int                   lat_q [$];
    longint               m_coef [NC];
    longint               m_off;
    logic                 prev_ov = 1'b0;
    int                   mon_t;
    logic signed [RW-1:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: offset + sum over slices of weight(b) * sum_p coef[2p + xor bit]
    function automatic longint model(input logic [XW-1:0] x);
        longint acc;
        longint s;
        logic [DW-1:0] a;
        logic [DW-1:0] c;
        acc = m_off;
        for (int b = 0; b < DW; b++) begin
            s = 0;
            for (int p = 0; p < NPAIR; p++) begin
                a = x[2*p*DW +: DW];
                c = x[(2*p+1)*DW +: DW];
                s += m_coef[2*p + ((a[b] ^ c[b]) ? 1 : 0)];
            end
            if (b == DW - 1) acc -= s * (longint'(1) << b);
            else             acc += s * (longint'(1) << b);
        end
        return acc;
    endfunction

    task automatic model_cfg(input int addr, input logic [CW-1:0] data);
        if (addr < NC)       m_coef[addr] = longint'($signed(data));
        else if (addr == NC) m_off = longint'($signed(data));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_coef[i] = 0;
        m_off = 0;
    endtask

    function automatic logic [DW-1:0] rsamp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return {1'b1, {(DW-1){1'b0}}};
            1:       return {1'b0, {(DW-1){1'b1}}};
            default: return r[DW-1:0];
        endcase
    endfunction

    function automatic logic [XW-1:0] rvec();
        logic [XW-1:0] x;
        for (int k = 0; k < NC; k++) x[k*DW +: DW] = rsamp();
        return x;
    endfunction

    // Inputs are driven 1 time unit after the rising edge
    task automatic cfg_write(input int addr, input logic [CW-1:0] data, input bit lands);
        logic [31:0] a;
        a = addr;
        cfg_we   = 1'b1;
        cfg_addr = a[CAW-1:0];
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (lands) model_cfg(addr, data);
    endtask

    task automatic issue(input logic [XW-1:0] x, input bit with_cfg,
                         input int addr, input logic [CW-1:0] data);
        bit ok;
        longint t;
        logic [31:0] a;
        ok = 1'b0;
        a  = addr;
        in_valid = 1'b1;
        x_in     = x;
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = a[CAW-1:0];
            cfg_data = data;
        end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 100 cycles");
        end else begin
            if (with_cfg) model_cfg(addr, data);
            t = model(x);
            sb_q.push_back(t[RW-1:0]);
            lat_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got pending=%0d expected 0 within 200 cycles", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: latency on first out_valid, result compare on each handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (lat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL latency: got out_valid expected no pending accept");
                end else begin
                    mon_t = lat_q.pop_front();
                    check("latency", longint'(cyc - mon_t), DW);
                    check("busy_in_done", busy, 1);
                    check("in_ready_in_done", in_ready, 0);
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL y_out: got unexpected result %0d expected none", y_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("y_out", y_out, mon_e);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [XW-1:0] x;
        logic [XW-1:0] one;
        longint        t;
        logic signed [RW-1:0] e_bp;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y_out", y_out, 0);
        @(posedge clk); #1;

        // Cleared table: zero result
        issue('0, 0, 0, '0);
        wait_idle();

        // coef[2p]=1, coef[2p+1]=0, offset 0
        for (int i = 0; i < NC; i++) cfg_write(i, (i % 2 == 0) ? 32'd1 : 32'd0, 1);
        cfg_write(NC, 32'd0, 1);
        issue('0, 0, 0, '0);
        wait_idle();
        check("zero_input_const", y_out, -8);
        one = '0;
        one[0] = 1'b1;
        issue(one, 0, 0, '0);
        wait_idle();
        check("lsb_const", y_out, -9);
        cfg_write(NC, 32'd100, 1);
        issue(one, 0, 0, '0);
        wait_idle();
        check("lsb_offset_const", y_out, 91);

        // Random table and offset, 200 random sample sets plus extremes
        for (int i = 0; i < NC; i++) cfg_write(i, $urandom, 1);
        cfg_write(NC, $urandom, 1);
        for (int n = 0; n < 200; n++) issue(rvec(), 0, 0, '0);
        x = '0;
        for (int k = 0; k < NC; k++) x[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
        issue(x, 0, 0, '0);
        for (int k = 0; k < NC; k++) x[k*DW +: DW] = (k % 2 == 0) ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        issue(x, 0, 0, '0);
        wait_idle();

        // Config protection: out-of-range write, writes while busy
        cfg_write(NC + 1, 32'h5555_5555, 1);
        issue(rvec(), 0, 0, '0);
        cfg_write(0, 32'd7, 0);
        check("busy_during_run", busy, 1);
        cfg_write(NC, 32'd999, 0);
        wait_idle();
        // Write and accept in the same idle cycle
        issue(rvec(), 1, 0, 32'd12345);
        wait_idle();
        issue(rvec(), 1, NC, 32'hFFFF_FF00);
        wait_idle();

        // Backpressure
        out_ready = 1'b0;
        x = rvec();
        t = model(x);
        e_bp = t[RW-1:0];
        issue(x, 0, 0, '0);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (out_valid) ok = 1'b1;
            end
            if (!ok) begin
                checks++; errors++;
                $display("FAIL bp_wait: got no out_valid expected out_valid within 100 cycles");
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            x_in = rvec();
            @(negedge clk);
            check("bp_y_hold", y_out, e_bp);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_released", out_valid, 0);
        check("bp_idle", in_ready, 1);
        @(posedge clk); #1;

        // Reset mid-run aborts and clears the table
        issue(rvec(), 0, 0, '0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        sb_q.delete();
        lat_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_y_out", y_out, 0);
        @(posedge clk); #1;
        issue(rvec(), 0, 0, '0);
        wait_idle();
        check("abort_cleared_table", y_out, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
